serial_adder: RTL and testbench

SERIAL_ADDER -- requirements
Module: serial_adder

---
 rtl/serial_adder.sv | 116 +++++++++++
 tb/tb_serial_adder.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_adder.sv
// serial_adder: bit-serial adder computing {cout, sum} = a + b + cin,
// LSB first, one bit per clock through a single full-adder cell.
//
// Ports:
//   clk      in   single clock, rising-edge active
//   reset_n  in   asynchronous active-low reset
//   start    in   add request, sampled only while idle
//   a, b     in   WIDTH-bit operands, captured on the accepting edge
//   cin      in   carry-in, captured on the accepting edge
//   busy     out  high while operand bits are being processed (WIDTH cycles)
//   done     out  one-cycle pulse when a result has just been loaded
//   sum      out  WIDTH-bit result of the last completed add
//   cout     out  carry-out of the last completed add
//
// Handshake: start is a level request. It is taken on any rising edge where
// the block is idle and start=1; operands are captured on that same edge.
// busy rises after that edge and stays high for WIDTH cycles. done then
// pulses for exactly one cycle, and sum/cout change only on the edge that
// raises done. start is ignored while busy or done is high. A start held high
// is taken again one idle cycle after done, so back-to-back adds repeat every
// WIDTH+2 cycles.
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] partial;
    logic             carry;
    logic [CW-1:0]    cnt;

    // The one full-adder cell: current operand LSBs plus the carry register.
    logic bit_sum;
    logic bit_carry;

    always_comb begin
        bit_sum   = a_sr[0] ^ b_sr[0] ^ carry;
        bit_carry = (a_sr[0] & b_sr[0]) | (a_sr[0] & carry) | (b_sr[0] & carry);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            a_sr    <= '0;
            b_sr    <= '0;
            partial <= '0;
            carry   <= 1'b0;
            cnt     <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            sum     <= '0;
            cout    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_sr    <= a;
                        b_sr    <= b;
                        carry   <= cin;
                        partial <= '0;
                        cnt     <= '0;
                        busy    <= 1'b1;
                        state   <= SHIFT;
                    end
                end
                SHIFT: begin
                    // New bit enters at the MSB; after WIDTH shifts bit 0 of
                    // the result has walked down to position 0.
                    partial <= {bit_sum, partial[WIDTH-1:1]};
                    carry   <= bit_carry;
                    a_sr    <= a_sr >> 1;
                    b_sr    <= b_sr >> 1;
                    cnt     <= cnt + CW'(1);
                    if (cnt == LAST_BIT) begin
                        sum   <= {bit_sum, partial[WIDTH-1:1]};
                        cout  <= bit_carry;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: self-checking bench for serial_adder (WIDTH=8).
// Expected {cout,sum} values are computed from the operands when a request
// is driven, queued, and popped when the DUT raises done.
module tb_serial_adder;

    localparam int W = 8;

    logic         clk;
    logic         reset_n;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;

    logic [W:0] exp_q[$];
    int checks;
    int errors;

    serial_adder #(.WIDTH(W)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (start),
        .a       (a),
        .b       (b),
        .cin     (cin),
        .busy    (busy),
        .done    (done),
        .sum     (sum),
        .cout    (cout)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- driver helpers ----------------
    // Drive one request across a single rising edge and queue its reference.
    // Returns at the falling edge just after the accepting edge.
    task automatic do_start(input logic [W-1:0] av, input logic [W-1:0] bv, input logic cv);
        @(negedge clk);
        start = 1'b1;
        a     = av;
        b     = bv;
        cin   = cv;
        exp_q.push_back({1'b0, av} + {1'b0, bv} + (W+1)'(cv));
        @(negedge clk);
        start = 1'b0;
        a     = W'($urandom);
        b     = W'($urandom);
        cin   = 1'($urandom);
    endtask

    // Walk falling edges until done is seen (bounded); counts busy samples.
    task automatic wait_done(output int busy_cycles, output bit timed_out);
        busy_cycles = 0;
        timed_out   = 1'b1;
        for (int i = 0; i < 40; i++) begin
            if (done) begin
                timed_out = 1'b0;
                break;
            end
            if (busy) busy_cycles++;
            @(negedge clk);
        end
    endtask

    function automatic logic [W:0] pop_exp();
        if (exp_q.size() == 0) return 'x;
        return exp_q.pop_front();
    endfunction

    // ---------------- tests ----------------
    task automatic test_reset();
        reset_n = 1'b0;
        start   = 1'b0;
        a       = '0;
        b       = '0;
        cin     = 1'b0;
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
        checks++; if (sum !== '0) begin errors++; $display("FAIL reset_sum got %h want 00", sum); end
        checks++; if (cout !== 1'b0) begin errors++; $display("FAIL reset_cout got %b want 0", cout); end
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        begin
            bit active;
            active = 1'b0;
            repeat (5) begin
                @(negedge clk);
                if (busy || done) active = 1'b1;
            end
            checks++; if (active !== 1'b0) begin errors++; $display("FAIL idle_hold got activity=%b want 0", active); end
        end
    endtask

    task automatic test_basic();
        int bc; bit to; logic [W:0] e;
        do_start(8'h5A, 8'h3C, 1'b0);
        wait_done(bc, to);
        checks++; if (to !== 1'b0) begin errors++; $display("FAIL basic_timeout got timeout want done"); end
        checks++; if (bc !== 8) begin errors++; $display("FAIL basic_busy_len got %0d want 8", bc); end
        e = pop_exp();
        checks++; if ({cout, sum} !== e) begin errors++; $display("FAIL basic_result got %h want %h", {cout, sum}, e); end
        checks++; if (sum !== 8'h96) begin errors++; $display("FAIL basic_sum got %h want 96", sum); end
        @(negedge clk);
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL basic_done_width got %b want 0", done); end
    endtask

    task automatic test_boundary();
        int bc; bit to; logic [W:0] e;
        do_start(8'hFF, 8'h01, 1'b0);
        wait_done(bc, to);
        checks++; if (to !== 1'b0) begin errors++; $display("FAIL carry_timeout got timeout want done"); end
        e = pop_exp();
        checks++; if ({cout, sum} !== e || e !== 9'h100) begin errors++; $display("FAIL carry_ff_01 got %h want 100", {cout, sum}); end
        do_start(8'hFF, 8'hFF, 1'b1);
        wait_done(bc, to);
        checks++; if (to !== 1'b0) begin errors++; $display("FAIL max_timeout got timeout want done"); end
        e = pop_exp();
        checks++; if ({cout, sum} !== e || e !== 9'h1FF) begin errors++; $display("FAIL max_ff_ff_1 got %h want 1ff", {cout, sum}); end
    endtask

    task automatic test_ignore_start();
        int bc; bit to; logic [W:0] e; int extra;
        do_start(8'h10, 8'h20, 1'b0);
        @(negedge clk);
        @(negedge clk);
        start = 1'b1;
        a     = 8'hAA;
        @(negedge clk);
        start = 1'b0;
        wait_done(bc, to);
        checks++; if (to !== 1'b0) begin errors++; $display("FAIL ignore_timeout got timeout want done"); end
        e = pop_exp();
        checks++; if ({cout, sum} !== e) begin errors++; $display("FAIL ignore_result got %h want %h", {cout, sum}, e); end
        extra = 0;
        repeat (25) begin
            @(negedge clk);
            if (done || busy) extra++;
        end
        checks++; if (extra !== 0) begin errors++; $display("FAIL ignore_single_pulse got %0d extra active cycles want 0", extra); end
    endtask

    task automatic test_back_to_back();
        int ndone; int cyc; int last_cyc; int low_run; logic [W:0] e;
        @(negedge clk);
        start = 1'b1;
        a     = 8'h01;
        b     = 8'h01;
        cin   = 1'b0;
        repeat (3) exp_q.push_back(9'h002);
        ndone = 0; cyc = 0; last_cyc = 0; low_run = 0;
        for (int i = 0; i < 60 && ndone < 3; i++) begin
            @(negedge clk);
            cyc++;
            if (done) begin
                e = pop_exp();
                checks++; if ({cout, sum} !== e) begin errors++; $display("FAIL b2b_result got %h want %h", {cout, sum}, e); end
                if (ndone > 0) begin
                    checks++; if (cyc - last_cyc !== W + 2) begin errors++; $display("FAIL b2b_period got %0d want %0d", cyc - last_cyc, W + 2); end
                end
                last_cyc = cyc;
                ndone++;
            end
            if (busy) begin
                if (ndone > 0 && low_run != 0) begin
                    checks++; if (low_run !== 2) begin errors++; $display("FAIL b2b_gap got %0d want 2", low_run); end
                end
                low_run = 0;
            end else begin
                low_run++;
            end
        end
        start = 1'b0;
        checks++; if (ndone !== 3) begin errors++; $display("FAIL b2b_count got %0d want 3", ndone); end
        exp_q.delete();
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset_mid();
        int bc; bit to; logic [W:0] e; int pulses;
        do_start(8'h77, 8'h22, 1'b0);
        repeat (3) @(negedge clk);
        @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy got %b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL midrst_done got %b want 0", done); end
        checks++; if (sum !== '0) begin errors++; $display("FAIL midrst_sum got %h want 00", sum); end
        checks++; if (cout !== 1'b0) begin errors++; $display("FAIL midrst_cout got %b want 0", cout); end
        exp_q.delete();
        @(negedge clk);
        reset_n = 1'b1;
        pulses = 0;
        repeat (15) begin
            @(negedge clk);
            if (done || busy) pulses++;
        end
        checks++; if (pulses !== 0) begin errors++; $display("FAIL midrst_no_done got %0d active cycles want 0", pulses); end
        do_start(8'h03, 8'h04, 1'b0);
        wait_done(bc, to);
        checks++; if (to !== 1'b0) begin errors++; $display("FAIL midrst_timeout got timeout want done"); end
        e = pop_exp();
        checks++; if ({cout, sum} !== e || e !== 9'h007) begin errors++; $display("FAIL midrst_result got %h want 007", {cout, sum}); end
    endtask

    task automatic test_random();
        logic [W:0] e; logic [W:0] last_res; bit stable; bit to;
        last_res = 9'h007;
        for (int n = 0; n < 1000; n++) begin
            do_start(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)));
            stable = 1'b1;
            to     = 1'b1;
            for (int i = 0; i < 40; i++) begin
                if (done) begin
                    to = 1'b0;
                    break;
                end
                if ({cout, sum} !== last_res) stable = 1'b0;
                a   = W'($urandom);
                b   = W'($urandom);
                cin = 1'($urandom);
                @(negedge clk);
            end
            e = pop_exp();
            checks++; if (to !== 1'b0) begin errors++; $display("FAIL rand_timeout add %0d got timeout want done", n); end
            checks++; if (stable !== 1'b1) begin errors++; $display("FAIL rand_stable add %0d got changed want %h held", n, last_res); end
            checks++; if ({cout, sum} !== e) begin errors++; $display("FAIL rand_result add %0d got %h want %h", n, {cout, sum}, e); end
            last_res = e;
        end
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_basic();
        test_boundary();
        test_ignore_start();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
